spi_master_arbiter: RTL and testbench
=====================================

# spi_master_arbiter

Round-robin arbiter and transaction sequencer that shares one SPI master between N_REQ host-side requesters. Grants one requester at a time, drives the master's FIFO-side data handshake and slave address for a whole burst, and routes received words back to the granted requester. Sits between the requesters and the SPI master's host port (FIFO / slave-address / dout side).

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 8, SPI word width
- ADDR_W, 3, slave address width
- LEN_W, 8, burst length field width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- req  in  N_REQ  per-requester transaction request (level)
- req_addr  in  N_REQ*ADDR_W  packed slave address per requester
- req_len  in  N_REQ*LEN_W  packed burst length minus one (0 → 1 word, 255 → 256 words)
- req_wdata  in  N_REQ*DATA_W  packed TX word per requester (first-word-fall-through)
- req_wvalid  in  N_REQ  TX word available
- req_wpop  out  N_REQ  one-cycle pop of the requester's TX word
- grant  out  N_REQ  one-hot, high for the whole transaction
- done  out  N_REQ  one-cycle pulse at transaction end
- rx_data  out  DATA_W  received word
- rx_valid  out  N_REQ  one-hot one-cycle pulse qualifying rx_data
- m_fifo_req_data  in  1  master requests a TX word
- m_fifo_din  out  DATA_W  TX word to master
- m_fifo_din_valid  out  1  TX word valid
- m_fifo_empty  out  1  no TX word available to master
- m_slave_addr  out  ADDR_W  slave select address to master
- m_busy  in  1  master busy
- m_dout  in  DATA_W  word received by master
- m_dout_valid  in  1  m_dout valid

## Operation
- FSM states: IDLE, LOAD, XFER, DRAIN, RELEASE.
- IDLE: if any req, select first set bit searching from ptr upward with wrap; → LOAD. ptr resets to 0.
- LOAD (1 cycle): assert grant[g]; latch m_slave_addr = req_addr[g], tx_left = rx_left = req_len[g]+1 (LEN_W+1 bits); → XFER.
- XFER: m_fifo_empty = (tx_left==0) | ~req_wvalid[g]. On m_fifo_req_data with m_fifo_empty==0: pulse req_wpop[g] same cycle, register req_wdata[g] into m_fifo_din, m_fifo_din_valid=1 next cycle for exactly one cycle, tx_left--. m_fifo_req_data while empty: ignored, no pop, no valid. → DRAIN when tx_left reaches 0.
- Receive (XFER and DRAIN): each m_dout_valid → rx_data=m_dout and rx_valid[g]=1 next cycle, rx_left-- (saturates at 0; extra words still forwarded).
- DRAIN: → RELEASE when rx_left==0 and m_busy==0 (same-cycle last m_dout_valid and m_busy fall counts).
- RELEASE (1 cycle): done[g]=1, grant cleared, ptr = g+1 mod N_REQ; → IDLE.
- req deassertion after grant is ignored; transaction always completes. req_addr/req_len sampled only in LOAD.
- No timeout: a master that never completes holds the grant.

## Timing
- Reset (rst low, asynchronous): state IDLE, ptr 0, counters 0; grant 0, done 0, rx_valid 0, req_wpop 0, rx_data 0, m_fifo_din 0, m_fifo_din_valid 0, m_fifo_empty 1, m_slave_addr 0. Reset mid-transaction aborts immediately; no done pulse.
- m_fifo_empty is 1 in every state except XFER.
- req sampled in IDLE → grant high 1 cycle later (LOAD) → m_fifo_empty may drop 2 cycles after req.
- m_fifo_req_data → m_fifo_din_valid: 1 cycle. m_dout_valid → rx_valid: 1 cycle.
- Minimum gap between transactions: RELEASE + IDLE = 2 cycles with grant low.
- All outputs registered except req_wpop and m_fifo_empty (combinational from state, counters, req_wvalid, m_fifo_req_data).

## Test plan
- Single burst: req[1], len 2 (3 words), wdata A1,A2,A3 → grant=0010, m_slave_addr=req_addr[1], three din pulses A1..A3, three rx_valid[1] pulses, done[1] once, grant 0.
- Round-robin: req=1111 held, len 0 each → grants in order 0,1,2,3,0; after reset mid-stream ptr restarts at 0.
- Underflow: req_wvalid low for 5 cycles mid-burst → m_fifo_empty=1, master requests ignored, no pop; burst resumes and completes with correct count.
- Drain: last TX word sent, m_busy high 20 more cycles with final m_dout_valid at cycle 18 → done only after m_busy low; simultaneous last m_dout_valid and m_busy fall → RELEASE next cycle.
- Max length: len 255 → exactly 256 pops and 256 din pulses, counter no wrap.
- Async reset asserted during XFER → all outputs at reset values without clock edge; no done.

Source files
------------

// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - round-robin arbiter and burst sequencer sharing one SPI master
module spi_master_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int LEN_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*LEN_W-1:0]    req_len,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    input  logic [N_REQ-1:0]          req_wvalid,
    output logic [N_REQ-1:0]          req_wpop,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          done,
    output logic [DATA_W-1:0]         rx_data,
    output logic [N_REQ-1:0]          rx_valid,
    input  logic                      m_fifo_req_data,
    output logic [DATA_W-1:0]         m_fifo_din,
    output logic                      m_fifo_din_valid,
    output logic                      m_fifo_empty,
    output logic [ADDR_W-1:0]         m_slave_addr,
    input  logic                      m_busy,
    input  logic [DATA_W-1:0]         m_dout,
    input  logic                      m_dout_valid
);
    localparam int IDX_W = $clog2(N_REQ);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_XFER    = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [LEN_W:0]   CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};

    logic [2:0]        state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  sel;
    logic [IDX_W-1:0]  pick;
    logic [IDX_W:0]    cand;
    logic              pick_found;
    logic [LEN_W:0]    tx_left;
    logic [LEN_W:0]    rx_left;
    logic [LEN_W:0]    rx_left_next;
    logic [N_REQ-1:0]  sel_onehot;
    logic              cur_wvalid;
    logic [DATA_W-1:0] cur_wdata;
    logic [LEN_W-1:0]  cur_len;
    logic              pop;
    logic              rx_phase;
    logic              rx_dec;

    // First requesting index at or above ptr, wrapping past N_REQ-1 back to 0.
    always_comb begin
        pick       = ptr;
        pick_found = 1'b0;
        cand       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!pick_found && req[cand[IDX_W-1:0]]) begin
                pick       = cand[IDX_W-1:0];
                pick_found = 1'b1;
            end
        end
    end

    assign sel_onehot   = ONE_HOT0 << sel;
    assign cur_wvalid   = req_wvalid[sel];
    assign cur_wdata    = req_wdata[int'(sel)*DATA_W +: DATA_W];
    assign cur_len      = req_len[int'(sel)*LEN_W +: LEN_W];

    assign m_fifo_empty = (state != S_XFER) || (tx_left == '0) || !cur_wvalid;
    assign pop          = (state == S_XFER) && m_fifo_req_data && !m_fifo_empty;
    assign req_wpop     = pop ? sel_onehot : '0;

    // Receive count saturates so stray words from the master are still forwarded.
    assign rx_phase     = (state == S_XFER) || (state == S_DRAIN);
    assign rx_dec       = m_dout_valid && (rx_left != '0);
    assign rx_left_next = rx_dec ? (rx_left - CNT_ONE) : rx_left;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= S_IDLE;
            ptr              <= '0;
            sel              <= '0;
            tx_left          <= '0;
            rx_left          <= '0;
            grant            <= '0;
            done             <= '0;
            rx_valid         <= '0;
            rx_data          <= '0;
            m_fifo_din       <= '0;
            m_fifo_din_valid <= 1'b0;
            m_slave_addr     <= '0;
        end else begin
            done             <= '0;
            rx_valid         <= '0;
            m_fifo_din_valid <= 1'b0;

            if (rx_phase) begin
                rx_left <= rx_left_next;
                if (m_dout_valid) begin
                    rx_data  <= m_dout;
                    rx_valid <= sel_onehot;
                end
            end

            if (pop) begin
                m_fifo_din       <= cur_wdata;
                m_fifo_din_valid <= 1'b1;
                tx_left          <= tx_left - CNT_ONE;
            end

            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        sel   <= pick;
                        grant <= ONE_HOT0 << pick;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    m_slave_addr <= req_addr[int'(sel)*ADDR_W +: ADDR_W];
                    tx_left      <= {1'b0, cur_len} + CNT_ONE;
                    rx_left      <= {1'b0, cur_len} + CNT_ONE;
                    state        <= S_XFER;
                end
                S_XFER: begin
                    if (pop && (tx_left == CNT_ONE)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((rx_left_next == '0) && !m_busy) begin
                        grant <= '0;
                        done  <= sel_onehot;
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    ptr   <= (sel == IDX_W'(N_REQ-1)) ? '0 : sel + IDX_W'(1);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb/tb_spi_master_arbiter.sv - randomized self-checking bench for spi_master_arbiter
module tb_spi_master_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]    req, req_wvalid, req_wpop, grant, done, rx_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rx_data, m_fifo_din, m_dout;
    logic            m_fifo_req_data, m_fifo_din_valid, m_fifo_empty, m_busy, m_dout_valid;
    logic [AW-1:0]   m_slave_addr;

    always #5 clk = ~clk;

    spi_master_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_len(req_len),
        .req_wdata(req_wdata), .req_wvalid(req_wvalid), .req_wpop(req_wpop),
        .grant(grant), .done(done), .rx_data(rx_data), .rx_valid(rx_valid),
        .m_fifo_req_data(m_fifo_req_data), .m_fifo_din(m_fifo_din),
        .m_fifo_din_valid(m_fifo_din_valid), .m_fifo_empty(m_fifo_empty),
        .m_slave_addr(m_slave_addr), .m_busy(m_busy), .m_dout(m_dout),
        .m_dout_valid(m_dout_valid)
    );

    int vectors = 0;
    int miscompares = 0;

    // Requester TX queues plus a loopback master returning each sent word inverted.
    logic [DW-1:0] txq[N][$];
    logic [DW-1:0] exp_words[$], din_log[$], rx_log[$], pend[$];
    logic [N-1:0]  reqmask, gmask, done_mask, last_grant;
    logic [AW-1:0] addr_g, addr_at_done;
    int gi = 0, mptr = 0, total, pops, hold, stall_at, stall_len, stall_cnt;
    int cyc = 0, cond_cyc, done_cyc, done_cnt, delivered, rx_wrong, gr_bad, grant_hits;
    bit active = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_wpop", req_wpop, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_din", m_fifo_din, 0);
        check("rst_din_valid", m_fifo_din_valid, 0);
        check("rst_empty", m_fifo_empty, 1);
        check("rst_addr", m_slave_addr, 0);
    endtask

    task automatic tick();
        logic [N-1:0]  pop_seen;
        logic [DW-1:0] w;
        bit            deliver;
        @(negedge clk);
        pop_seen = req_wpop;
        if (rst) begin
            check("pop_rule", req_wpop, (m_fifo_req_data && !m_fifo_empty) ? grant : '0);
            if ((grant & req_wvalid) == '0) check("empty_no_word", m_fifo_empty, 1);
            if (grant != '0) begin
                if (grant === gmask) grant_hits++;
                else gr_bad++;
            end
            if (m_fifo_din_valid) begin
                din_log.push_back(m_fifo_din);
                pend.push_back(m_fifo_din ^ 8'hFF);
            end
            if (rx_valid != '0) begin
                if (rx_valid === gmask) rx_log.push_back(rx_data);
                else rx_wrong++;
            end
        end
        if (done != '0) begin
            done_cnt++;
            done_mask    = done_mask | done;
            done_cyc     = cyc;
            addr_at_done = m_slave_addr;
            active       = 0;
        end
        last_grant = grant;
        @(posedge clk);
        #1;
        cyc++;
        for (int r = 0; r < N; r++) begin
            if (pop_seen[r] && txq[r].size() > 0) begin
                w = txq[r].pop_front();
                if (r == gi) pops++;
            end
        end
        if (stall_cnt > 0) stall_cnt--;
        else if (active && stall_len > 0 && pops == stall_at) begin
            stall_cnt = stall_len;
            stall_len = 0;
        end
        if (active && txq[gi].size() == 0 && hold > 0) hold--;
        deliver = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
        m_dout_valid = deliver;
        if (deliver) begin
            m_dout = pend.pop_front();
            delivered++;
        end else begin
            m_dout = DW'($urandom);
        end
        m_busy = (hold > 0) || (pend.size() > 0) || (active && txq[gi].size() > 0);
        // Release must follow the first cycle with every word back and the master idle.
        if (active && cond_cyc < 0 && delivered == total && !m_busy) cond_cyc = cyc;
        m_fifo_req_data = ($urandom_range(0, 1) == 1);
        req = active ? reqmask : '0;
        for (int r = 0; r < N; r++) begin
            req_wvalid[r] = (txq[r].size() > 0) && (stall_cnt == 0);
            req_wdata[r*DW +: DW] = (txq[r].size() > 0) ? txq[r][0] : '0;
        end
    endtask

    task automatic reset_mid();
        logic [DW-1:0] w;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        for (int r = 0; r < N; r++) txq[r].delete();
        pend.delete();
        active = 0; hold = 0; stall_cnt = 0; stall_len = 0; done_cnt = 0;
        req = '0; req_wvalid = '0; m_fifo_req_data = 0; m_dout_valid = 0; m_busy = 0;
        tick();
        tick();
        check("no_done_in_reset", done_cnt, 0);
        rst = 1'b1;
        mptr = 0;
        tick();
    endtask

    task automatic do_txn(input logic [N-1:0] mask, input int len_fix, input int hold_in,
                          input int st_at, input int st_len, input logic [DW-1:0] first_word,
                          input int abort_at);
        int len_r, err_d, err_r;
        logic [AW-1:0] a;
        logic [DW-1:0] w;
        gi = -1;
        for (int i = 0; i < N; i++) if (gi < 0 && mask[(mptr + i) % N]) gi = (mptr + i) % N;
        gmask = '0;
        gmask[gi] = 1'b1;
        exp_words.delete(); din_log.delete(); rx_log.delete(); pend.delete();
        for (int r = 0; r < N; r++) begin
            if (mask[r]) begin
                txq[r].delete();
                len_r = (len_fix >= 0) ? len_fix : $urandom_range(0, 7);
                a = AW'($urandom);
                req_len[r*LW +: LW]  = LW'(len_r);
                req_addr[r*AW +: AW] = a;
                for (int k = 0; k <= len_r; k++) begin
                    w = (first_word != '0 && r == gi) ? first_word + DW'(k) : DW'($urandom);
                    txq[r].push_back(w);
                    if (r == gi) exp_words.push_back(w);
                end
                if (r == gi) begin
                    total  = len_r + 1;
                    addr_g = a;
                end
            end
        end
        pops = 0; delivered = 0; cond_cyc = -1; done_cnt = 0; done_mask = '0; done_cyc = -1;
        rx_wrong = 0; gr_bad = 0; grant_hits = 0;
        hold = hold_in; stall_at = st_at; stall_len = st_len; stall_cnt = 0;
        reqmask = mask; req = mask; active = 1;
        for (int t = 0; t < 6000 && done_cnt == 0; t++) begin
            tick();
            if (abort_at > 0 && pops >= abort_at) break;
        end
        if (abort_at > 0) begin
            reset_mid();
            return;
        end
        check("done_timeout", done_cnt, 1);
        tick();
        check("done_once", done_cnt, 1);
        check("done_who", done_mask, gmask);
        check("grant_after", last_grant, 0);
        check("grant_held", grant_hits > 0, 1);
        check("grant_wrong", gr_bad, 0);
        check("slave_addr", addr_at_done, addr_g);
        check("pop_count", pops, total);
        check("din_count", din_log.size(), total);
        check("rx_count", rx_log.size(), total);
        check("rx_onehot", rx_wrong, 0);
        err_d = 0;
        err_r = 0;
        for (int i = 0; i < total; i++) begin
            if (i < din_log.size() && din_log[i] !== exp_words[i]) err_d++;
            if (i < rx_log.size() && rx_log[i] !== (exp_words[i] ^ 8'hFF)) err_r++;
        end
        check("din_data", err_d, 0);
        check("rx_data", err_r, 0);
        check("release_timing", done_cyc, cond_cyc + 1);
        mptr = (gi + 1) % N;
    endtask

    initial begin
        req = '0; req_addr = '0; req_len = '0; req_wdata = '0; req_wvalid = '0;
        m_fifo_req_data = 0; m_busy = 0; m_dout = '0; m_dout_valid = 0;
        gmask = '0; last_grant = '0; reqmask = '0;
        #1 rst = 1'b0;
        #2 check_reset_outputs();
        tick();
        tick();
        rst = 1'b1;
        tick();
        do_txn(4'b0010, 2, 0, -1, 0, 8'hA1, 0);
        do_txn(4'b0001, 9, 0, 3, 5, 8'h00, 0);
        do_txn(4'b1000, 3, 20, -1, 0, 8'h00, 0);
        for (int n = 0; n < 12; n++) begin
            do_txn(N'($urandom_range(1, 15)), -1, $urandom_range(0, 3),
                   $urandom_range(0, 4), $urandom_range(0, 4), 8'h00, 0);
        end
        do_txn(4'b0100, 255, 0, -1, 0, 8'h00, 0);
        do_txn(4'b1111, 5, 0, -1, 0, 8'h00, 2);
        for (int n = 0; n < 5; n++) do_txn(4'b1111, 0, 0, -1, 0, 8'h00, 0);
        do_txn(4'b1111, 5, 0, -1, 0, 8'h00, 2);
        do_txn(4'b1111, 0, 0, -1, 0, 8'h00, 0);
        check("rr_restart", gi, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
